// File: rtl/regfile_write_arbiter_pkg.sv
// ============================================================================
// Module      : regfile_write_arbiter_pkg
// Description : Shared widths and source encoding for the register-file write
//               arbiter and its pending-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REGADDR_WIDTH
`define REGADDR_WIDTH 5
`endif

package regfile_write_arbiter_pkg;

    // Default widths follow the core-wide datapath definitions.
    localparam int c_data_w_default = `DATA_WIDTH;
    localparam int c_addr_w_default = `REGADDR_WIDTH;

    // Writeback source encoding, also used as the round-robin pointer value.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module      : regfile_scoreboard
// Description : Pending-write scoreboard. One busy bit per architectural
//               register; set by the issue stage, cleared when the write
//               port commits. Register 0 is never tracked.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               i_set_valid/_idx    - reserve a destination register
//               i_clr_valid/_idx    - write port commit (wr_enable/wr_select)
//               o_busy              - busy vector, bit i = write to ri pending
//               o_idle              - no pending writes and no write driven
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_write_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_addr_w_default
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_set_valid,
    input  logic [ADDR_W-1:0]      i_set_idx,
    input  logic                   i_clr_valid,
    input  logic [ADDR_W-1:0]      i_clr_idx,
    output logic [(2**ADDR_W)-1:0] o_busy,
    output logic                   o_idle
);

    localparam int c_n_regs = 2 ** ADDR_W;

    // Bit 0 is not stored at all, so it is zero even before the first reset.
    logic [c_n_regs-1:1] r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            for (int i = 1; i < c_n_regs; i++) begin
                // A new reservation beats a commit to the same index: the
                // reserved write is still outstanding after this edge.
                if (i_set_valid && (i_set_idx == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (i_clr_valid && (i_clr_idx == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    assign o_busy = {r_busy, 1'b0};
    assign o_idle = (o_busy == '0) && !i_clr_valid;

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Arbitrates the register file's single write port between the
//               ALU and memory writeback sources (valid/ready), drives the
//               write port from a registered output stage and maintains the
//               pending-write scoreboard for hazard detection.
// Ports       : clk, reset                    - clock, sync active-high reset
//               alu_valid/rd/data, alu_ready  - ALU writeback handshake
//               mem_valid/rd/data, mem_ready  - load writeback handshake
//               reserve_valid/rd              - issue-stage reservation
//               wr_data/wr_select/wr_enable   - register file write port
//               busy, idle                    - scoreboard state
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W       = c_data_w_default,
    parameter int ADDR_W       = c_addr_w_default,
    parameter int MEM_PRIORITY = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [ADDR_W-1:0]      mem_rd,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   mem_ready,
    input  logic                   reserve_valid,
    input  logic [ADDR_W-1:0]      reserve_rd,
    output logic [DATA_W-1:0]      wr_data,
    output logic [ADDR_W-1:0]      wr_select,
    output logic                   wr_enable,
    output logic [(2**ADDR_W)-1:0] busy,
    output logic                   idle
);

    // Last granted source. Reset to MEM so that ALU is next in a tie.
    src_e              r_last_src;
    logic [DATA_W-1:0] r_wr_data;
    logic [ADDR_W-1:0] r_wr_select;
    logic              r_wr_enable;

    logic              w_alu_grant;
    logic              w_mem_grant;

    // Grant depends only on valids, the pointer and reset, never on rd/data.
    always_comb begin
        w_alu_grant = 1'b0;
        w_mem_grant = 1'b0;
        if (!reset) begin
            if (alu_valid && mem_valid) begin
                if ((MEM_PRIORITY != 0) || (r_last_src == SRC_ALU)) begin
                    w_mem_grant = 1'b1;
                end else begin
                    w_alu_grant = 1'b1;
                end
            end else begin
                w_alu_grant = alu_valid;
                w_mem_grant = mem_valid;
            end
        end
    end

    assign alu_ready = w_alu_grant;
    assign mem_ready = w_mem_grant;

    // Output stage. A grant is always an accept since ready implies valid.
    // rd=0 requests are consumed but never raise the write enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_data   <= '0;
            r_wr_select <= '0;
            r_wr_enable <= 1'b0;
            r_last_src  <= SRC_MEM;
        end else if (w_alu_grant) begin
            r_wr_data   <= alu_data;
            r_wr_select <= alu_rd;
            r_wr_enable <= (alu_rd != '0);
            r_last_src  <= SRC_ALU;
        end else if (w_mem_grant) begin
            r_wr_data   <= mem_data;
            r_wr_select <= mem_rd;
            r_wr_enable <= (mem_rd != '0);
            r_last_src  <= SRC_MEM;
        end else begin
            r_wr_enable <= 1'b0;
        end
    end

    assign wr_data   = r_wr_data;
    assign wr_select = r_wr_select;
    assign wr_enable = r_wr_enable;

    // Clearing on the driven write port lines the clear up with the edge at
    // which the register file itself captures the value.
    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .i_set_valid (reserve_valid),
        .i_set_idx   (reserve_rd),
        .i_clr_valid (r_wr_enable),
        .i_clr_idx   (r_wr_select),
        .o_busy      (busy),
        .o_idle      (idle)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Self-checking bench for regfile_write_arbiter. Instance dut0
//               is round-robin, dut1 gives memory priority. Expected writes
//               are queued when stimulus is driven and popped when dut0
//               drives its write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid, mem_valid, reserve_valid;
    logic [4:0]  alu_rd, mem_rd, reserve_rd;
    logic [31:0] alu_data, mem_data;

    logic        alu_ready0, mem_ready0, wr_enable0, idle0;
    logic [31:0] wr_data0, busy0;
    logic [4:0]  wr_select0;
    logic        alu_ready1, mem_ready1, wr_enable1, idle1;
    logic [31:0] wr_data1, busy1;
    logic [4:0]  wr_select1;

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .MEM_PRIORITY(0)) dut0 (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready0),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready0),
        .reserve_valid(reserve_valid), .reserve_rd(reserve_rd),
        .wr_data(wr_data0), .wr_select(wr_select0), .wr_enable(wr_enable0),
        .busy(busy0), .idle(idle0)
    );

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .MEM_PRIORITY(1)) dut1 (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready1),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready1),
        .reserve_valid(reserve_valid), .reserve_rd(reserve_rd),
        .wr_data(wr_data1), .wr_select(wr_select1), .wr_enable(wr_enable1),
        .busy(busy1), .idle(idle1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t q[$];

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        exp_ar;
        logic        exp_mr;
    } vec_t;
    vec_t vt[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        reserve_valid = 1'b0; reserve_rd = '0;
    endtask

    task automatic push_wr(input logic [4:0] sel, input logic [31:0] data);
        wr_t e;
        e.sel  = sel;
        e.data = data;
        e.cyc  = cyc + 1;
        q.push_back(e);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        drive_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        q.delete();
        mon_en = 1'b1;
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] ard,
                                input logic mv, input logic [4:0] mrd,
                                input logic ear, input logic emr);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = 32'hA000_0000 | 32'(ard);
        v.mv = mv; v.mrd = mrd; v.md = 32'hB000_0000 | 32'(mrd);
        v.exp_ar = ear; v.exp_mr = emr;
        return v;
    endfunction

    // Write-port monitor for dut0: every driven write must match the oldest
    // queued expectation in content and cycle; an overdue expectation with
    // no write is reported as missing.
    always @(negedge clk) begin : p_mon
        wr_t e;
        if (mon_en) begin
            if (wr_enable0 === 1'b1) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got sel=%0d data=0x%0h expected no write",
                             wr_select0, wr_data0);
                end else begin
                    e = q.pop_front();
                    chk("wr_select", 64'(wr_select0), 64'(e.sel));
                    chk("wr_data", 64'(wr_data0), 64'(e.data));
                    chk("wr_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missing_write: got wr_enable=%b expected write sel=%0d data=0x%0h",
                         wr_enable0, e.sel, e.data);
            end
        end
    end

    initial begin
        // Contention table: each source holds its request until accepted.
        vt[0]  = mk(1'b1, 5'd1,  1'b1, 5'd11, 1'b1, 1'b0);
        vt[1]  = mk(1'b1, 5'd2,  1'b1, 5'd11, 1'b0, 1'b1);
        vt[2]  = mk(1'b1, 5'd2,  1'b1, 5'd12, 1'b1, 1'b0);
        vt[3]  = mk(1'b1, 5'd3,  1'b1, 5'd12, 1'b0, 1'b1);
        vt[4]  = mk(1'b1, 5'd3,  1'b1, 5'd13, 1'b1, 1'b0);
        vt[5]  = mk(1'b1, 5'd4,  1'b1, 5'd13, 1'b0, 1'b1);
        vt[6]  = mk(1'b1, 5'd4,  1'b1, 5'd14, 1'b1, 1'b0);
        vt[7]  = mk(1'b0, 5'd0,  1'b1, 5'd14, 1'b0, 1'b1);
        vt[8]  = mk(1'b0, 5'd0,  1'b1, 5'd20, 1'b0, 1'b1);
        vt[9]  = mk(1'b1, 5'd21, 1'b0, 5'd0,  1'b1, 1'b0);
        vt[10] = mk(1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0);

        // ---- Reset with requests present ----
        drive_idle();
        reset = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd3;
        mem_valid = 1'b1; mem_rd = 5'd4;
        tick();
        chk("rst_alu_ready", 64'(alu_ready0), 64'd0);
        chk("rst_mem_ready", 64'(mem_ready0), 64'd0);
        chk("rst_alu_ready_p1", 64'(alu_ready1), 64'd0);
        chk("rst_mem_ready_p1", 64'(mem_ready1), 64'd0);
        chk("rst_wr_enable", 64'(wr_enable0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_wr_data", 64'(wr_data0), 64'd0);
        tick();
        reset = 1'b0;
        drive_idle();
        mon_en = 1'b1;
        tick();
        chk("rst_idle", 64'(idle0), 64'd1);

        // ---- Single ALU write with reservation ----
        reserve_valid = 1'b1; reserve_rd = 5'd5;
        tick();
        reserve_valid = 1'b0; reserve_rd = '0;
        chk("sgl_busy5_set", 64'(busy0[5]), 64'd1);
        chk("sgl_idle_busy", 64'(idle0), 64'd0);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1;
        chk("sgl_alu_ready", 64'(alu_ready0), 64'd1);
        chk("sgl_mem_ready", 64'(mem_ready0), 64'd0);
        push_wr(5'd5, 32'hDEAD_BEEF);
        tick();
        drive_idle();
        chk("sgl_wr_enable", 64'(wr_enable0), 64'd1);
        chk("sgl_busy5_hold", 64'(busy0[5]), 64'd1);
        tick();
        chk("sgl_busy5_clr", 64'(busy0[5]), 64'd0);
        chk("sgl_wr_enable_off", 64'(wr_enable0), 64'd0);
        chk("sgl_wr_data_hold", 64'(wr_data0), 64'hDEAD_BEEF);
        chk("sgl_idle", 64'(idle0), 64'd1);

        // ---- Round-robin contention, table driven ----
        do_reset();
        for (int i = 0; i < 11; i++) begin
            alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_data = vt[i].ad;
            mem_valid = vt[i].mv; mem_rd = vt[i].mrd; mem_data = vt[i].md;
            #1;
            chk($sformatf("rr_alu_ready[%0d]", i), 64'(alu_ready0), 64'(vt[i].exp_ar));
            chk($sformatf("rr_mem_ready[%0d]", i), 64'(mem_ready0), 64'(vt[i].exp_mr));
            if (vt[i].exp_ar) push_wr(vt[i].ard, vt[i].ad);
            if (vt[i].exp_mr) push_wr(vt[i].mrd, vt[i].md);
            tick();
        end
        drive_idle();
        tick();
        tick();
        chk("rr_queue_drained", 64'(q.size()), 64'd0);

        // ---- Memory priority (dut1) ----
        do_reset();
        mon_en = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'hA000_0002;
        for (int k = 0; k < 3; k++) begin
            mem_valid = 1'b1; mem_rd = 5'(16 + k); mem_data = 32'hB000_0010 + 32'(k);
            #1;
            chk($sformatf("mp_mem_ready[%0d]", k), 64'(mem_ready1), 64'd1);
            chk($sformatf("mp_alu_ready[%0d]", k), 64'(alu_ready1), 64'd0);
            tick();
            chk($sformatf("mp_wr_select[%0d]", k), 64'(wr_select1), 64'(16 + k));
        end
        mem_valid = 1'b0;
        #1;
        chk("mp_alu_ready_free", 64'(alu_ready1), 64'd1);
        chk("mp_mem_ready_free", 64'(mem_ready1), 64'd0);
        tick();
        chk("mp_alu_write_sel", 64'(wr_select1), 64'd2);
        chk("mp_alu_write_en", 64'(wr_enable1), 64'd1);
        do_reset();

        // ---- r0 request ----
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
        reserve_valid = 1'b1; reserve_rd = 5'd0;
        #1;
        chk("r0_alu_ready", 64'(alu_ready0), 64'd1);
        tick();
        drive_idle();
        chk("r0_wr_enable", 64'(wr_enable0), 64'd0);
        chk("r0_busy", 64'(busy0), 64'd0);
        chk("r0_wr_data", 64'(wr_data0), 64'h0000_1234);
        chk("r0_idle", 64'(idle0), 64'd1);

        // ---- Set/clear collision on r7 ----
        reserve_valid = 1'b1; reserve_rd = 5'd7;
        tick();
        reserve_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777_0007;
        push_wr(5'd7, 32'h7777_0007);
        tick();
        alu_valid = 1'b0;
        reserve_valid = 1'b1; reserve_rd = 5'd7;
        chk("col_wr_enable", 64'(wr_enable0), 64'd1);
        tick();
        reserve_valid = 1'b0;
        chk("col_busy7_kept", 64'(busy0[7]), 64'd1);
        tick();
        chk("col_busy7_stable", 64'(busy0[7]), 64'd1);

        // ---- Reset with a write in flight ----
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9999_0009;
        push_wr(5'd9, 32'h9999_0009);
        tick();
        chk("inflight_wr_enable", 64'(wr_enable0), 64'd1);
        reset = 1'b1;
        alu_rd = 5'd10; alu_data = 32'h1010_0010;
        #1;
        chk("inflight_alu_ready_rst", 64'(alu_ready0), 64'd0);
        tick();
        chk("inflight_wr_enable_rst", 64'(wr_enable0), 64'd0);
        chk("inflight_busy_rst", 64'(busy0), 64'd0);
        reset = 1'b0;
        drive_idle();
        tick();
        tick();
        chk("end_idle", 64'(idle0), 64'd1);
        chk("end_idle_p1", 64'(idle1), 64'd1);
        chk("end_queue_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
